body_integrator: RTL
====================

BODY_INTEGRATOR -- requirements
Module: body_integrator

Interface
REQ-001 Parameter MAX_BODIES, default 10: maximum bodies integrated per step.
REQ-002 Parameter DT_SHIFT, default 4: timestep is 2^-DT_SHIFT, applied as an arithmetic right shift.
REQ-003 CLK  in  1  system clock, 50 MHz.
REQ-004 RESET_N  in  1  reset, synchronous and active-low.
REQ-005 START  in  1  level request from regfile START register bit 0.
REQ-006 DONE  out  1  step complete, held per REQ-020.
REQ-007 RD_ADDR  out  8  regfile read address.
REQ-008 RD_DATA  in  32  regfile word at RD_ADDR registered on the previous cycle, so read latency is 1.
REQ-009 NUM_BODIES  in  32  regfile word 0.
REQ-010 WE  out  1  triple-write request.
REQ-011 WR_GRANT  in  1  write accepted this cycle; low while an Avalon write has priority.
REQ-012 ADDR1, ADDR2, ADDR3  out  8 each  write addresses.
REQ-013 DATA1, DATA2, DATA3  out  32 each  write data.

Function
REQ-014 States SHALL be IDLE, READ, WR_VEL, WR_POS, DONE.
- IDLE to READ: START=1 while in IDLE and effective count N>0.
- IDLE to DONE: START=1 while in IDLE and N=0.
REQ-015 N SHALL be min(NUM_BODIES, MAX_BODIES), latched in IDLE on start; the body index b runs 1..N.
REQ-016 READ SHALL issue 9 addresses on consecutive cycles, in this order: ACC_X+b, ACC_Y+b, ACC_Z+b, VEL_X+b, VEL_Y+b, VEL_Z+b, POS_X+b, POS_Y+b, POS_Z+b. It captures RD_DATA one cycle behind each address and lasts 10 cycles.
REQ-017 Velocity and position update:
- WR_VEL SHALL drive v' = sat(v + (a >>> DT_SHIFT)) per axis to VEL_X/Y/Z+b.
- WR_POS SHALL drive p' = sat(p + (v' >>> DT_SHIFT)) per axis to POS_X/Y/Z+b, using the new velocity (semi-implicit Euler).
REQ-018 Arithmetic SHALL be 32-bit two's complement with the sum formed in 33 bits, then saturated to 0x7FFFFFFF or 0x80000000.
REQ-019 Write handshake:
- WE SHALL be high only in WR_VEL and WR_POS.
- A write SHALL complete only on a cycle with WE=1 and WR_GRANT=1.
- While WR_GRANT=0, the state, addresses and data SHALL hold unchanged.
REQ-020 After WR_POS completes: if b<N, increment b and go to READ; otherwise go to DONE.
REQ-021 DONE SHALL assert DONE=1 and stay there while START=1, then return to IDLE on the first cycle START=0. It SHALL hold for at least one cycle even if START is already low.
REQ-022 Deasserting START during READ, WR_VEL or WR_POS SHALL NOT abort the step.
REQ-023 Latency with continuous grant: START sampled in IDLE at cycle T gives DONE=1 at T+1+12N.
REQ-024 A new step SHALL start only from IDLE, so START must fall and rise again between steps.
REQ-025 Registers other than the 6 per-body velocity and position words SHALL never be written.

Reset
REQ-026 While RESET_N=0 at a clock edge, state SHALL go to IDLE with b=1.
- Reset values: DONE=0, WE=0, RD_ADDR=0, ADDR1-3=0, DATA1-3=0.
REQ-027 Reset SHALL take effect mid-step; partial writes already completed SHALL NOT be undone.

Structure
REQ-028 A shared package gravsim_pkg SHALL hold:
- register offsets NUM=0, START=1, DONE=2, ACC_X=82, ACC_Y=92, ACC_Z=102, VEL_X=52, VEL_Y=62, VEL_Z=72, POS_X=22, POS_Y=32, POS_Z=42;
- the state enum;
- the saturating-add function.
REQ-029 One sub-module, sat_shift_add, SHALL compute sat(x + (y >>> DT_SHIFT)); it is instantiated 3 times, one per axis.

Verification
REQ-030 N=1, DT_SHIFT=4, body 1: a_x=256, v_x=32, p_x=1000 -> writes v_x=48, then p_x=1003; DONE at T+13.
REQ-031 a_y=-17, v_y=0, p_y=0 -> v_y=-2 (floor shift), p_y=-1.
REQ-032 v_z=0x7FFFFFF0, a_z=0x7FFFFFFF -> v_z=0x7FFFFFFF, with no wrap to a negative value.
REQ-033 NUM_BODIES=0 -> no WE pulses and DONE=1 at T+1; NUM_BODIES=15 -> exactly 10 bodies updated and DONE at T+121.
REQ-034 N=2, WR_GRANT=0 for 5 cycles during the first WR_VEL -> WE, addresses and data stable for those cycles, correct final values, DONE at T+30.
REQ-035 RESET_N=0 for one cycle during body 2 READ -> IDLE with all outputs 0; body 1 results stay written; the next START pulse completes a full step.

Source files
------------

// File: rtl/gravsim_pkg.sv
// Shared definitions for the gravity-simulation register file and integrator.
//
// Contents:
//   REG_*         register-file word offsets (axis blocks are indexed by body 1..N)
//   state_e       integrator state encoding
//   sat_add       32-bit signed add with saturation instead of wrap-around
//   read_offset   base offset of the idx-th word fetched for one body

package gravsim_pkg;

    localparam logic [7:0] REG_NUM   = 8'd0;
    localparam logic [7:0] REG_START = 8'd1;
    localparam logic [7:0] REG_DONE  = 8'd2;
    localparam logic [7:0] REG_POS_X = 8'd22;
    localparam logic [7:0] REG_POS_Y = 8'd32;
    localparam logic [7:0] REG_POS_Z = 8'd42;
    localparam logic [7:0] REG_VEL_X = 8'd52;
    localparam logic [7:0] REG_VEL_Y = 8'd62;
    localparam logic [7:0] REG_VEL_Z = 8'd72;
    localparam logic [7:0] REG_ACC_X = 8'd82;
    localparam logic [7:0] REG_ACC_Y = 8'd92;
    localparam logic [7:0] REG_ACC_Z = 8'd102;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WR_VEL = 3'd2,
        ST_WR_POS = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // The sum is formed one bit wider so overflow shows up as the two top
    // bits disagreeing; the extra top bit then tells us which rail to clamp to.
    function automatic logic [31:0] sat_add(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] sum;
        sum = {x[31], x} + {y[31], y};
        if (sum[32] != sum[31]) begin
            sat_add = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

    // Fetch order for one body: acceleration, velocity, position, each X/Y/Z.
    function automatic logic [7:0] read_offset(input logic [3:0] idx);
        case (idx)
            4'd0:    read_offset = REG_ACC_X;
            4'd1:    read_offset = REG_ACC_Y;
            4'd2:    read_offset = REG_ACC_Z;
            4'd3:    read_offset = REG_VEL_X;
            4'd4:    read_offset = REG_VEL_Y;
            4'd5:    read_offset = REG_VEL_Z;
            4'd6:    read_offset = REG_POS_X;
            4'd7:    read_offset = REG_POS_Y;
            4'd8:    read_offset = REG_POS_Z;
            default: read_offset = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_shift_add.sv
// One axis of the integrator datapath: sum = sat(x + (y >>> DT_SHIFT)).
//
// Ports:
//   x_in   32-bit signed base value (velocity or position)
//   y_in   32-bit signed rate value (acceleration or velocity), scaled by 2^-DT_SHIFT
//   sum    32-bit saturated result

module sat_shift_add
    import gravsim_pkg::*;
#(
    parameter int DT_SHIFT = 4
) (
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic [31:0] sum
);

    logic [31:0] y_scaled;

    // Arithmetic shift rounds toward minus infinity, so negative rates keep
    // their sign even when smaller in magnitude than one timestep unit.
    always_comb begin
        y_scaled = $signed(y_in) >>> DT_SHIFT;
        sum      = sat_add(x_in, y_scaled);
    end

endmodule

// File: rtl/body_integrator.sv
// Semi-implicit Euler integrator for up to MAX_BODIES bodies held in a
// register file. Each body is fetched (9 words), its velocity is updated and
// written back, then its position is updated from the new velocity and
// written back.
//
// Ports:
//   CLK, RESET_N      clock and synchronous active-low reset
//   START             level request; a step begins only from idle
//   DONE              high once the step has finished, until START drops
//   RD_ADDR, RD_DATA  register-file read port (data arrives one cycle later)
//   NUM_BODIES        requested body count (clamped to MAX_BODIES)
//   WE, WR_GRANT      triple-write request and its per-cycle acceptance
//   ADDR1..3, DATA1..3  the three X/Y/Z words of the current write

module body_integrator
    import gravsim_pkg::*;
#(
    parameter int MAX_BODIES = 10,
    parameter int DT_SHIFT   = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    output logic        DONE,
    output logic [7:0]  RD_ADDR,
    input  logic [31:0] RD_DATA,
    input  logic [31:0] NUM_BODIES,
    output logic        WE,
    input  logic        WR_GRANT,
    output logic [7:0]  ADDR1,
    output logic [7:0]  ADDR2,
    output logic [7:0]  ADDR3,
    output logic [31:0] DATA1,
    output logic [31:0] DATA2,
    output logic [31:0] DATA3
);

    state_e            state_q, state_d;
    logic [7:0]        b_q, b_d;
    logic [7:0]        n_q, n_d;
    logic [3:0]        cnt_q, cnt_d;
    // Words 0-2 acceleration, 3-5 velocity, 6-8 position of the current body.
    logic [8:0][31:0]  rdbuf_q, rdbuf_d;
    logic [2:0][31:0]  op_x, op_y, res;
    logic [7:0]        n_eff;

    always_comb begin
        if (NUM_BODIES > 32'(MAX_BODIES)) begin
            n_eff = 8'(MAX_BODIES);
        end else begin
            n_eff = NUM_BODIES[7:0];
        end
    end

    // The three adders are shared between both write phases: velocity uses
    // (v, a), position uses (p, v') where v' has already replaced v in the
    // buffer when the velocity write was granted.
    always_comb begin
        op_x = '0;
        op_y = '0;
        for (int i = 0; i < 3; i++) begin
            if (state_q == ST_WR_POS) begin
                op_x[i] = rdbuf_q[6 + i];
                op_y[i] = rdbuf_q[3 + i];
            end else begin
                op_x[i] = rdbuf_q[3 + i];
                op_y[i] = rdbuf_q[i];
            end
        end
    end

    sat_shift_add #(.DT_SHIFT(DT_SHIFT)) u_sat_x (.x_in(op_x[0]), .y_in(op_y[0]), .sum(res[0]));
    sat_shift_add #(.DT_SHIFT(DT_SHIFT)) u_sat_y (.x_in(op_x[1]), .y_in(op_y[1]), .sum(res[1]));
    sat_shift_add #(.DT_SHIFT(DT_SHIFT)) u_sat_z (.x_in(op_x[2]), .y_in(op_y[2]), .sum(res[2]));

    // Sequencing. READ runs cnt 0..9: addresses go out on 0..8 and the data
    // for address k is captured on cnt k+1. Write states only advance on a
    // granted cycle, so everything holds while the bus is busy.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        rdbuf_d = rdbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    n_d     = n_eff;
                    b_d     = 8'd1;
                    cnt_d   = 4'd0;
                    state_d = (n_eff == 8'd0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (cnt_q != 4'd0) begin
                    rdbuf_d[cnt_q - 4'd1] = RD_DATA;
                end
                if (cnt_q == 4'd9) begin
                    cnt_d   = 4'd0;
                    state_d = ST_WR_VEL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WR_VEL: begin
                if (WR_GRANT) begin
                    for (int i = 0; i < 3; i++) begin
                        rdbuf_d[3 + i] = res[i];
                    end
                    state_d = ST_WR_POS;
                end
            end
            ST_WR_POS: begin
                if (WR_GRANT) begin
                    if (b_q < n_q) begin
                        b_d     = b_q + 8'd1;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!START) begin
                    b_d     = 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so they are zero
    // whenever the integrator sits in IDLE (including right after reset).
    always_comb begin
        DONE    = (state_q == ST_DONE);
        WE      = (state_q == ST_WR_VEL) || (state_q == ST_WR_POS);
        RD_ADDR = 8'd0;
        ADDR1   = 8'd0;
        ADDR2   = 8'd0;
        ADDR3   = 8'd0;
        DATA1   = 32'd0;
        DATA2   = 32'd0;
        DATA3   = 32'd0;
        if (state_q == ST_READ && cnt_q != 4'd9) begin
            RD_ADDR = read_offset(cnt_q) + b_q;
        end
        if (state_q == ST_WR_VEL) begin
            ADDR1 = REG_VEL_X + b_q;
            ADDR2 = REG_VEL_Y + b_q;
            ADDR3 = REG_VEL_Z + b_q;
        end else if (state_q == ST_WR_POS) begin
            ADDR1 = REG_POS_X + b_q;
            ADDR2 = REG_POS_Y + b_q;
            ADDR3 = REG_POS_Z + b_q;
        end
        if (WE) begin
            DATA1 = res[0];
            DATA2 = res[1];
            DATA3 = res[2];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            b_q     <= 8'd1;
            n_q     <= 8'd0;
            cnt_q   <= 4'd0;
            rdbuf_q <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            rdbuf_q <= rdbuf_d;
        end
    end

endmodule
